// File: rtl/parking_controller_mc.sv
// Single-gate parking controller: PIN entry with retry limit, occupancy tracking with
// lot-full lockout, gate-open timeout and tailgate detection.
module parking_controller_mc #(
  parameter int unsigned      PIN_W     = 8,
  parameter logic [PIN_W-1:0] PIN_CODE  = 8'h26,
  parameter int unsigned      MAX_TRIES = 3,
  parameter int unsigned      CAPACITY  = 16,
  parameter int unsigned      OCC_W     = 5,
  parameter int unsigned      GATE_TMO  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PIN_W-1:0] pin,
  input  logic             pin_vld,
  input  logic             senr_e,
  input  logic             senr_x,
  input  logic             car_leave,
  output logic             ent_pin,
  output logic             gate_o,
  output logic             gate_cls,
  output logic             alm_pin,
  output logic             alm_blkg,
  output logic             alm_tmo,
  output logic             lot_full,
  output logic [OCC_W-1:0] occupancy
);

  localparam int unsigned TryW = $clog2(MAX_TRIES + 1);
  localparam int unsigned TmrW = $clog2(GATE_TMO);

  typedef enum logic [2:0] {
    StIdle,
    StWaitPin,
    StGateOpen,
    StPinAlarm,
    StBlockAlarm
  } state_e;

  state_e          state_q, state_d;
  logic [TryW-1:0] tries_q, tries_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic            lot_full_q, lot_full_d;
  logic            alm_tmo_q, alm_tmo_d;

  logic            pin_ok;
  logic            pass;
  logic [TryW-1:0] tries_inc;

  assign pin_ok    = pin_vld && (pin == PIN_CODE);
  assign tries_inc = tries_q + TryW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      tries_q    <= '0;
      timer_q    <= '0;
      occ_q      <= '0;
      lot_full_q <= 1'b0;
      alm_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      timer_q    <= timer_d;
      occ_q      <= occ_d;
      lot_full_q <= lot_full_d;
      alm_tmo_q  <= alm_tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    timer_d   = timer_q;
    alm_tmo_d = 1'b0;
    pass      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (senr_e && !lot_full_q) state_d = StWaitPin;
      end
      StWaitPin: begin
        // A PIN strobe wins over the vehicle backing away in the same cycle.
        if (pin_vld) begin
          if (pin_ok) begin
            state_d = StGateOpen;
            tries_d = '0;
            timer_d = '0;
          end else begin
            tries_d = tries_inc;
            if (tries_inc == TryW'(MAX_TRIES)) state_d = StPinAlarm;
          end
        end else if (!senr_e) begin
          state_d = StIdle;
          tries_d = '0;
        end
      end
      StGateOpen: begin
        if (senr_e && senr_x) begin
          state_d = StBlockAlarm;
        end else if (senr_x) begin
          state_d = StIdle;
          pass    = 1'b1;
        end else if (timer_q == TmrW'(GATE_TMO - 1)) begin
          state_d   = StIdle;
          alm_tmo_d = 1'b1;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StPinAlarm, StBlockAlarm: begin
        if (pin_ok) begin
          state_d = StGateOpen;
          tries_d = '0;
          timer_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        tries_d = '0;
        timer_d = '0;
      end
    endcase
  end

  // Simultaneous pass and leave cancel out; both ends saturate.
  always_comb begin
    occ_d = occ_q;
    if (pass && !car_leave) begin
      if (occ_q < OCC_W'(CAPACITY)) occ_d = occ_q + OCC_W'(1);
    end else if (car_leave && !pass) begin
      if (occ_q != '0) occ_d = occ_q - OCC_W'(1);
    end
    lot_full_d = (occ_q == OCC_W'(CAPACITY));
  end

  always_comb begin
    ent_pin  = 1'b0;
    gate_o   = 1'b0;
    gate_cls = 1'b1;
    alm_pin  = 1'b0;
    alm_blkg = 1'b0;
    unique case (state_q)
      StIdle: ;
      StWaitPin: ent_pin = 1'b1;
      StGateOpen: begin
        gate_o   = 1'b1;
        gate_cls = 1'b0;
      end
      StPinAlarm: begin
        ent_pin = 1'b1;
        alm_pin = 1'b1;
      end
      StBlockAlarm: begin
        ent_pin  = 1'b1;
        alm_blkg = 1'b1;
      end
      default: ;
    endcase
  end

  assign alm_tmo   = alm_tmo_q;
  assign lot_full  = lot_full_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_parking_controller_mc.sv
// Bench for parking_controller_mc: two instances (default lot and a 2-space lot), each
// checked every cycle against a rule-level model, plus directed literal expectations.
module tb_parking_controller_mc;

  localparam int TMO   = 32;
  localparam int CODE  = 'h26;
  localparam int TRIES = 3;
  localparam int CAP_A = 16;
  localparam int CAP_B = 2;

  localparam int M_IDLE = 0, M_WAIT = 1, M_OPEN = 2, M_PALM = 3, M_BALM = 4;

  typedef struct {
    int mode;
    int tries;
    int timer;
    int occ;
    bit full;
    bit tmo;
  } mdl_t;

  typedef struct {
    logic [7:0] pin;
    bit         vld;
    bit         se;
    bit         sx;
    bit         leave;
  } in_t;

  int checks = 0;
  int errors = 0;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [7:0] a_pin, b_pin;
  logic a_vld, a_se, a_sx, a_leave;
  logic b_vld, b_se, b_sx, b_leave;
  logic a_ent, a_go, a_gc, a_ap, a_ab, a_tmo, a_full;
  logic b_ent, b_go, b_gc, b_ap, b_ab, b_tmo, b_full;
  logic [4:0] a_occ;
  logic [1:0] b_occ;

  parking_controller_mc #(
    .PIN_W(8), .PIN_CODE(8'h26), .MAX_TRIES(TRIES), .CAPACITY(CAP_A), .OCC_W(5),
    .GATE_TMO(TMO)
  ) u_dut_a (
    .clock(clock), .reset(reset), .pin(a_pin), .pin_vld(a_vld), .senr_e(a_se),
    .senr_x(a_sx), .car_leave(a_leave), .ent_pin(a_ent), .gate_o(a_go), .gate_cls(a_gc),
    .alm_pin(a_ap), .alm_blkg(a_ab), .alm_tmo(a_tmo), .lot_full(a_full), .occupancy(a_occ)
  );

  parking_controller_mc #(
    .PIN_W(8), .PIN_CODE(8'h26), .MAX_TRIES(TRIES), .CAPACITY(CAP_B), .OCC_W(2),
    .GATE_TMO(TMO)
  ) u_dut_b (
    .clock(clock), .reset(reset), .pin(b_pin), .pin_vld(b_vld), .senr_e(b_se),
    .senr_x(b_sx), .car_leave(b_leave), .ent_pin(b_ent), .gate_o(b_go), .gate_cls(b_gc),
    .alm_pin(b_ap), .alm_blkg(b_ab), .alm_tmo(b_tmo), .lot_full(b_full), .occupancy(b_occ)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic mdl_t mreset();
    mdl_t n;
    n.mode = M_IDLE; n.tries = 0; n.timer = 0; n.occ = 0; n.full = 0; n.tmo = 0;
    return n;
  endfunction

  function automatic in_t mk_in(logic [7:0] p, logic v, logic se, logic sx, logic lv);
    in_t i;
    i.pin = p; i.vld = v; i.se = se; i.sx = sx; i.leave = lv;
    return i;
  endfunction

  // One clock of the lot rules, written against the behavioural description.
  function automatic mdl_t mstep(mdl_t m, in_t i, int cap);
    mdl_t n = m;
    bit good = i.vld && (int'(i.pin) == CODE);
    bit pass = 0;
    n.tmo  = 0;
    n.full = (m.occ == cap);
    case (m.mode)
      M_IDLE: if (i.se && !m.full) n.mode = M_WAIT;
      M_WAIT: begin
        if (i.vld && good) begin
          n.mode = M_OPEN; n.tries = 0; n.timer = 0;
        end else if (i.vld) begin
          n.tries = m.tries + 1;
          if (n.tries == TRIES) n.mode = M_PALM;
        end else if (!i.se) begin
          n.mode = M_IDLE; n.tries = 0;
        end
      end
      M_OPEN: begin
        if (i.se && i.sx) n.mode = M_BALM;
        else if (i.sx) begin n.mode = M_IDLE; pass = 1; end
        else if (m.timer == TMO - 1) begin n.mode = M_IDLE; n.tmo = 1; end
        else n.timer = m.timer + 1;
      end
      default: if (good) begin n.mode = M_OPEN; n.tries = 0; n.timer = 0; end
    endcase
    if (pass && !i.leave && m.occ < cap) n.occ = m.occ + 1;
    else if (i.leave && !pass && m.occ > 0) n.occ = m.occ - 1;
    return n;
  endfunction

  mdl_t ma, mb;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      ma <= mreset();
      mb <= mreset();
    end else begin
      ma <= mstep(ma, mk_in(a_pin, a_vld, a_se, a_sx, a_leave), CAP_A);
      mb <= mstep(mb, mk_in(b_pin, b_vld, b_se, b_sx, b_leave), CAP_B);
    end
  end

  task automatic cmp_out(input string tag, input mdl_t m, input logic ent, input logic go,
                         input logic gc, input logic ap, input logic ab, input logic tmo,
                         input logic full, input logic [7:0] occ);
    chk({tag, ".ent_pin"}, 32'(ent), 32'(m.mode inside {M_WAIT, M_PALM, M_BALM}));
    chk({tag, ".gate_o"}, 32'(go), 32'(m.mode == M_OPEN));
    chk({tag, ".gate_cls"}, 32'(gc), 32'(m.mode != M_OPEN));
    chk({tag, ".alm_pin"}, 32'(ap), 32'(m.mode == M_PALM));
    chk({tag, ".alm_blkg"}, 32'(ab), 32'(m.mode == M_BALM));
    chk({tag, ".alm_tmo"}, 32'(tmo), 32'(m.tmo));
    chk({tag, ".lot_full"}, 32'(full), 32'(m.full));
    chk({tag, ".occupancy"}, 32'(occ), 32'(m.occ));
  endtask

  always @(negedge clock) begin
    if (reset) begin
      cmp_out("mdlA", ma, a_ent, a_go, a_gc, a_ap, a_ab, a_tmo, a_full, 8'(a_occ));
      cmp_out("mdlB", mb, b_ent, b_go, b_gc, b_ap, b_ab, b_tmo, b_full, 8'(b_occ));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input logic [7:0] p, input logic v, input logic se, input logic sx,
                       input logic lv);
    a_pin = p; a_vld = v; a_se = se; a_sx = sx; a_leave = lv;
  endtask

  task automatic set_b(input logic [7:0] p, input logic v, input logic se, input logic sx,
                       input logic lv);
    b_pin = p; b_vld = v; b_se = se; b_sx = sx; b_leave = lv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set_a(8'h00, 0, 0, 0, 0);
    set_b(8'h00, 0, 0, 0, 0);
    #1 reset = 1'b0;
    #11;
    chk("rst.gate_cls", 32'(a_gc), 32'd1);
    chk("rst.gate_o", 32'(a_go), 32'd0);
    chk("rst.ent_pin", 32'(a_ent), 32'd0);
    chk("rst.alarms", 32'({a_ap, a_ab, a_tmo, a_full}), 32'd0);
    chk("rst.occupancy", 32'(a_occ), 32'd0);
    chk("rstB.gate_cls", 32'(b_gc), 32'd1);
    reset = 1'b1;
    tick();

    // Nominal entry
    set_a(8'h00, 0, 1, 0, 0); tick();
    chk("nom.ent_pin", 32'(a_ent), 32'd1);
    set_a(8'h26, 1, 1, 0, 0); tick();
    chk("nom.gate_o", 32'(a_go), 32'd1);
    chk("nom.gate_cls_open", 32'(a_gc), 32'd0);
    set_a(8'h00, 0, 0, 1, 0); tick();
    chk("nom.gate_cls_pass", 32'(a_gc), 32'd1);
    chk("nom.occupancy", 32'(a_occ), 32'd1);

    // Wrong PIN three times, then recovery
    set_a(8'h00, 0, 1, 0, 0); tick();
    set_a(8'h11, 1, 1, 0, 0); tick(); tick();
    chk("wp.no_alarm_2", 32'(a_ap), 32'd0);
    tick();
    chk("wp.alarm_3", 32'(a_ap), 32'd1);
    set_a(8'h55, 1, 1, 0, 0); tick();
    chk("wp.ignored", 32'(a_ap), 32'd1);
    set_a(8'h26, 1, 1, 0, 0); tick();
    chk("wp.alarm_clear", 32'(a_ap), 32'd0);
    chk("wp.gate_o", 32'(a_go), 32'd1);
    set_a(8'h00, 0, 0, 1, 0); tick();
    chk("wp.occupancy", 32'(a_occ), 32'd2);
    set_a(8'h00, 0, 1, 0, 0); tick();
    set_a(8'h11, 1, 1, 0, 0); tick(); tick();
    chk("wp.tries_reset", 32'(a_ap), 32'd0);
    chk("wp.still_wait", 32'(a_ent), 32'd1);
    set_a(8'h00, 0, 0, 0, 0); tick();
    chk("wp.walk_away", 32'(a_ent), 32'd0);

    // Tailgate
    set_a(8'h00, 0, 1, 0, 0); tick();
    set_a(8'h26, 1, 1, 0, 0); tick();
    set_a(8'h00, 0, 1, 1, 0); tick();
    chk("tg.alm_blkg", 32'(a_ab), 32'd1);
    chk("tg.gate_o", 32'(a_go), 32'd0);
    set_a(8'h00, 0, 0, 1, 0); tick();
    chk("tg.sensors_ignored", 32'(a_ab), 32'd1);
    chk("tg.no_count", 32'(a_occ), 32'd2);
    set_a(8'h26, 1, 0, 0, 0); tick();
    chk("tg.clear", 32'(a_ab), 32'd0);
    chk("tg.reopen", 32'(a_go), 32'd1);
    set_a(8'h00, 0, 0, 1, 0); tick();
    chk("tg.occupancy", 32'(a_occ), 32'd3);

    // Gate-open timeout
    set_a(8'h00, 0, 1, 0, 0); tick();
    set_a(8'h26, 1, 1, 0, 0); tick();
    set_a(8'h00, 0, 0, 0, 0);
    for (int k = 0; k < TMO - 1; k++) tick();
    chk("tmo.still_open", 32'(a_go), 32'd1);
    tick();
    chk("tmo.gate_cls", 32'(a_gc), 32'd1);
    chk("tmo.alm_tmo", 32'(a_tmo), 32'd1);
    chk("tmo.occupancy", 32'(a_occ), 32'd3);
    tick();
    chk("tmo.pulse_end", 32'(a_tmo), 32'd0);

    // Asynchronous reset while the gate is open
    set_a(8'h00, 0, 1, 0, 0); tick();
    set_a(8'h26, 1, 1, 0, 0); tick();
    set_a(8'h00, 0, 1, 0, 0);
    chk("ar.open_before", 32'(a_go), 32'd1);
    chk("ar.occ_before", 32'(a_occ), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("ar.gate_cls", 32'(a_gc), 32'd1);
    chk("ar.gate_o", 32'(a_go), 32'd0);
    chk("ar.occupancy", 32'(a_occ), 32'd0);
    #2 reset = 1'b1;
    set_a(8'h00, 0, 0, 0, 0);
    tick();

    // Full lot on the two-space instance
    for (int n = 0; n < 2; n++) begin
      set_b(8'h00, 0, 1, 0, 0); tick();
      set_b(8'h26, 1, 1, 0, 0); tick();
      set_b(8'h00, 0, 0, 1, 0); tick();
    end
    chk("full.occ2", 32'(b_occ), 32'd2);
    set_b(8'h00, 0, 0, 0, 0); tick();
    chk("full.lot_full", 32'(b_full), 32'd1);
    set_b(8'h00, 0, 1, 0, 0); tick();
    chk("full.lockout", 32'(b_ent), 32'd0);
    tick();
    chk("full.lockout2", 32'(b_ent), 32'd0);
    set_b(8'h00, 0, 0, 0, 1); tick();
    chk("full.leave_occ", 32'(b_occ), 32'd1);
    set_b(8'h00, 0, 0, 0, 0); tick();
    chk("full.lot_free", 32'(b_full), 32'd0);
    set_b(8'h00, 0, 1, 0, 0); tick();
    set_b(8'h26, 1, 1, 0, 0); tick();
    set_b(8'h00, 0, 0, 1, 1); tick();
    chk("full.pass_and_leave", 32'(b_occ), 32'd1);
    set_b(8'h00, 0, 0, 0, 1); tick();
    chk("full.leave_to_zero", 32'(b_occ), 32'd0);
    tick();
    chk("full.sat_zero", 32'(b_occ), 32'd0);
    set_b(8'h00, 0, 0, 0, 0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
